game_move_sequencer: RTL and testbench

//  Sequential initiator for the 2048 move datapath. Holds the 4x4 board in registers.

---
 rtl/game_move_if.sv | 30 +++
 rtl/game_move_sequencer.sv | 119 +++++++++++
 tb/tb_game_move_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/game_move_if.sv
// game_move_if: board, button, flag and status bundle between front end, sequencer and move-control block
interface game_move_if #(
    parameter int TILE_W = 32
);
    logic                        start;
    logic                        btn_left;
    logic                        btn_right;
    logic                        btn_up;
    logic                        btn_down;
    logic [3:0][3:0][TILE_W-1:0] moved_board;
    logic                        gano;
    logic                        perdio;
    logic [3:0][3:0][TILE_W-1:0] board_q;
    logic [2:0]                  selector;
    logic [TILE_W-1:0]           win_goal;
    logic                        busy;
    logic                        won;
    logic                        lost;
    logic [15:0]                 move_count;

    modport master (
        output start, btn_left, btn_right, btn_up, btn_down, moved_board, gano, perdio,
        input  board_q, selector, win_goal, busy, won, lost, move_count
    );

    modport slave (
        input  start, btn_left, btn_right, btn_up, btn_down, moved_board, gano, perdio,
        output board_q, selector, win_goal, busy, won, lost, move_count
    );
endinterface

// File: rtl/game_move_sequencer.sv
// game_move_sequencer: 2048 game sequencer (board register, moves, tile spawn, win/lose); SPAWN_FOUR_EN enables 4-tiles
module game_move_sequencer #(
    parameter int          TILE_W    = 32,
    parameter int          WIN_VALUE = 2048,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic        clk,
    input logic        rst_n,
    game_move_if.slave bus
);
    typedef enum logic [3:0] {IDLE, CLEAR, SPAWN, WAIT, MOVE, SETTLE, SAMPLE, WON, LOST} state_t;

    state_t                      state, state_nx;
    logic [3:0][3:0][TILE_W-1:0] board;
    logic [15:0]                 lfsr, lfsr_nx, count;
    logic [3:0]                  btn_now, btn_q, rise, probe_idx, probes;
    logic [2:0]                  dir;
    logic [1:0]                  init_left;
    logic                        cell_empty, moved, spawn_enter;
    logic [TILE_W-1:0]           tile;

    assign btn_now    = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
    assign rise       = btn_now & ~btn_q;
    assign cell_empty = board[probe_idx[3:2]][probe_idx[1:0]] == '0;
    assign moved      = bus.moved_board != board;
    assign lfsr_nx    = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

`ifdef SPAWN_FOUR_EN
    logic four;
    assign tile = four ? TILE_W'(4) : TILE_W'(2);
    // decide 2 vs 4 from the same lfsr value that picks the start cell
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) four <= 1'b0;
        else if (spawn_enter) four <= lfsr[7:5] == 3'b000;
`else
    assign tile = TILE_W'(2);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next state; spawn_enter marks every entry into a fresh spawn pass
    always_comb begin
        state_nx    = state;
        spawn_enter = 1'b0;
        case (state)
            CLEAR: begin
                state_nx    = SPAWN;
                spawn_enter = 1'b1;
            end
            WAIT: if (|rise) state_nx = MOVE;
            MOVE: begin
                state_nx    = moved ? SPAWN : WAIT;
                spawn_enter = moved;
            end
            SPAWN: if (cell_empty) begin
                state_nx    = init_left == 2'd2 ? SPAWN : init_left == 2'd1 ? WAIT : SETTLE;
                spawn_enter = init_left == 2'd2;
            end else if (probes == 4'd15) state_nx = LOST;
            SETTLE: state_nx = SAMPLE;
            SAMPLE: state_nx = bus.gano ? WON : bus.perdio ? LOST : WAIT;
            default: state_nx = state;
        endcase
        if (bus.start) begin
            state_nx    = CLEAR;
            spawn_enter = 1'b0;
        end
    end

    // board, counters, lfsr, button history and spawn probe pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board     <= '0;
            lfsr      <= LFSR_SEED;
            count     <= '0;
            btn_q     <= '0;
            dir       <= '0;
            probe_idx <= '0;
            probes    <= '0;
            init_left <= '0;
        end else begin
            btn_q <= btn_now;
            if (bus.start) begin
                board <= '0;
                count <= '0;
                lfsr  <= LFSR_SEED;
            end else begin
                if (spawn_enter) begin
                    probe_idx <= lfsr[3:0];
                    probes    <= '0;
                    lfsr      <= lfsr_nx;
                end
                if (state == CLEAR) init_left <= 2'd2;
                if (state == WAIT) dir <= rise[0] ? 3'd1 : rise[1] ? 3'd2 : rise[2] ? 3'd3 : 3'd4;
                if (state == MOVE && moved) begin
                    board <= bus.moved_board;
                    count <= count + {15'd0, count != 16'hFFFF};
                end
                if (state == SPAWN && cell_empty) begin
                    board[probe_idx[3:2]][probe_idx[1:0]] <= tile;
                    init_left <= init_left - {1'b0, init_left != 2'd0};
                end else if (state == SPAWN) begin
                    probe_idx <= probe_idx + 4'd1;
                    probes    <= probes + 4'd1;
                end
            end
        end
    end

    assign bus.board_q    = board;
    assign bus.selector   = state == MOVE ? dir : 3'd0;
    assign bus.win_goal   = TILE_W'(WIN_VALUE);
    assign bus.busy       = !(state inside {IDLE, WAIT, WON, LOST});
    assign bus.won        = state == WON;
    assign bus.lost       = state == LOST;
    assign bus.move_count = count;
endmodule

// File: tb/tb_game_move_sequencer.sv
// tb_game_move_sequencer: directed and randomized play against a cell-level game model
module tb_game_move_sequencer;
    typedef logic [3:0][3:0][31:0] board_t;
    localparam int SEED   = 16'hACE1;
    localparam int M_IDLE = 0, M_WAIT = 1, M_WON = 2, M_LOST = 3;

    logic       clk = 1'b0, rst_n = 1'b0;
    int         checks = 0, failures = 0;
    int         busy_cnt = 0, sel_cnt = 0;
    logic [2:0] last_sel = 3'd0;
    int         mb[16];
    int         mlfsr, mcount, mstate;

    game_move_if #(.TILE_W(32)) bus();
    game_move_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.selector != 3'd0) begin
            sel_cnt++;
            last_sel = bus.selector;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lfsr_step(input int l);
        int b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic board_t mpack();
        board_t r;
        for (int i = 0; i < 16; i++) r[i / 4][i % 4] = 32'(mb[i]);
        return r;
    endfunction

    function automatic void munpack(input board_t v);
        for (int i = 0; i < 16; i++) mb[i] = int'(v[i / 4][i % 4]);
    endfunction

    function automatic int spawn();
        int st = mlfsr & 15;
        int tile = 2;
`ifdef SPAWN_FOUR_EN
        if (((mlfsr >> 5) & 7) == 0) tile = 4;
`endif
        mlfsr = lfsr_step(mlfsr);
        for (int i = 0; i < 16; i++)
            if (mb[(st + i) % 16] == 0) begin
                mb[(st + i) % 16] = tile;
                return i + 1;
            end
        return 17;
    endfunction

    task automatic set_btn(input logic [3:0] m);
        {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left} = m;
    endtask

    task automatic check_state();
        check("board", bus.board_q, mpack());
        check("move_count", bus.move_count, mcount);
        check("won", bus.won, mstate == M_WON);
        check("lost", bus.lost, mstate == M_LOST);
        check("busy_idle", bus.busy, 0);
    endtask

    task automatic do_start();
        int b0, k1, k2;
        b0 = busy_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 60 && bus.busy; i++) @(negedge clk);
        foreach (mb[i]) mb[i] = 0;
        mcount = 0;
        mlfsr  = SEED;
        k1     = spawn();
        k2     = spawn();
        mstate = M_WAIT;
        check("start_busy_cycles", busy_cnt - b0, 1 + k1 + k2);
        check_state();
    endtask

    task automatic do_move(input logic [3:0] m, input board_t mv, input logic g, input logic p,
                           input logic [3:0] late);
        int b0, s0, k, exp_busy, exp_scnt;
        logic [2:0] exp_sel;
        b0 = busy_cnt;
        s0 = sel_cnt;
        bus.moved_board = mv;
        bus.gano        = g;
        bus.perdio      = p;
        set_btn(m);
        @(negedge clk);
        set_btn(4'b0);
        for (int i = 0; i < 60 && bus.busy; i++) begin
            @(negedge clk);
            set_btn(i == 0 && bus.busy ? late : 4'b0);
        end
        repeat (3) @(negedge clk);
        exp_sel  = 3'd0;
        exp_scnt = 0;
        exp_busy = 0;
        if (mstate == M_WAIT && m != 4'b0) begin
            exp_scnt = 1;
            exp_busy = 1;
            exp_sel  = m[0] ? 3'd1 : m[1] ? 3'd2 : m[2] ? 3'd3 : 3'd4;
            if (mv != mpack()) begin
                munpack(mv);
                if (mcount < 65535) mcount++;
                k = spawn();
                exp_busy += k > 16 ? 16 : k + 2;
                mstate = k > 16 ? M_LOST : g ? M_WON : p ? M_LOST : M_WAIT;
            end
        end
        check("sel_pulses", sel_cnt - s0, exp_scnt);
        if (exp_scnt != 0) check("selector", last_sel, exp_sel);
        check("busy_cycles", busy_cnt - b0, exp_busy);
        check_state();
    endtask

    initial begin
        board_t mv;
        int e, k;
        bus.start = 1'b0;
        set_btn(4'b0);
        bus.moved_board = '0;
        bus.gano = 1'b0;
        bus.perdio = 1'b0;
        mstate = M_IDLE;
        mcount = 0;
        mlfsr = SEED;
        foreach (mb[i]) mb[i] = 0;
        #1;
        check_state();
        check("selector_rst", bus.selector, 0);
        check("win_goal", bus.win_goal, 2048);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        do_move(4'b0001, mpack(), 1'b0, 1'b0, 4'b0);
        mv = mpack();
        mv[0][0] = mv[0][0] == 0 ? 32'd2 : 32'd0;
        do_move(4'b0001, mv, 1'b0, 1'b0, 4'b0);
        mv = mpack();
        mv[3][3] = mv[3][3] == 0 ? 32'd8 : 32'd0;
        do_move(4'b1001, mv, 1'b0, 1'b0, 4'b0010);
        e = ((mlfsr & 15) + 15) % 16;
        for (int i = 0; i < 16; i++) mv[i / 4][i % 4] = i == e ? 32'd0 : 32'd4;
        do_move(4'b0100, mv, 1'b0, 1'b0, 4'b0);
        for (int i = 0; i < 16; i++) mv[i / 4][i % 4] = 32'd8;
        do_move(4'b1000, mv, 1'b0, 1'b0, 4'b0);
        do_start();
        mv = mpack();
        mv[1][2] = mv[1][2] == 0 ? 32'd16 : 32'd0;
        do_move(4'b0010, mv, 1'b1, 1'b1, 4'b0);
        mv = mpack();
        mv[2][1] = mv[2][1] == 0 ? 32'd32 : 32'd0;
        do_move(4'b0001, mv, 1'b0, 1'b0, 4'b0);
        do_start();
        mv = mpack();
        mv[0][3] = mv[0][3] == 0 ? 32'd4 : 32'd0;
        bus.moved_board = mv;
        set_btn(4'b0001);
        @(negedge clk);
        set_btn(4'b0);
        check("selector_in_move", bus.selector, 1);
        #2 rst_n = 1'b0;
        #1;
        foreach (mb[i]) mb[i] = 0;
        mcount = 0;
        mlfsr = SEED;
        mstate = M_IDLE;
        check_state();
        check("selector_rst_async", bus.selector, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        for (int n = 0; n < 40; n++) begin
            if (mstate != M_WAIT) do_start();
            mv = mpack();
            if ($urandom_range(0, 3) != 0)
                repeat ($urandom_range(1, 3)) begin
                    e = $urandom_range(0, 15);
                    k = $urandom_range(0, 5);
                    mv[e / 4][e % 4] = k == 0 ? 32'd0 : 32'd1 << k;
                end
            do_move(4'($urandom_range(1, 15)), mv, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0, 4'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
